// File: rtl/jt51_sh_pkg.sv
// jt51_sh_pkg
// Shared definitions for the circulating slot memory (jt51_sh_rw) and its
// storage ring (jt51_sh_ring):
//   - port_state_e : state encoding used by both request/ack port FSMs
//   - slot_width() : slot index width for a given ring depth
package jt51_sh_pkg;

  typedef enum logic [1:0] {
    PORT_IDLE = 2'd0,
    PORT_WAIT = 2'd1,
    PORT_ACK  = 2'd2
  } port_state_e;

  // Width of a slot index for a ring of n slots (never narrower than 1 bit).
  function automatic int slot_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/jt51_sh_ring.sv
// jt51_sh_ring
// Storage ring of `stages` entries of `width` bits. On each cen tick the tail
// re-enters at the head (or head_val replaces it when head_we is set) and every
// other entry moves one place toward the tail. The slot counter names the slot
// whose value currently sits at the tail.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears ring and counter)
//   cen           advance enable
//   head_we       replace the recirculating value with head_val on this tick
//   head_val      value injected at the head
//   tail          value of slot `slot`
//   slot          index of the slot at the tail
module jt51_sh_ring
  import jt51_sh_pkg::*;
#(
  parameter  int width  = 5,
  parameter  int stages = 32,
  localparam int SW     = slot_width(stages)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             head_we,
  input  logic [width-1:0] head_val,
  output logic [width-1:0] tail,
  output logic [SW-1:0]    slot
);

  logic [width-1:0] ring_q [stages];
  logic [width-1:0] head_d;
  logic [SW-1:0]    slot_q;
  logic [SW-1:0]    slot_d;

  // Head input and wrapping slot counter for the next tick.
  always_comb begin
    head_d = head_we ? head_val : ring_q[stages-1];
    if (slot_q == SW'(stages - 1)) begin
      slot_d = '0;
    end else begin
      slot_d = slot_q + SW'(1);
    end
  end

  // Ring storage and slot counter; everything holds while cen is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < stages; i++) begin
        ring_q[i] <= '0;
      end
      slot_q <= '0;
    end else if (cen) begin
      ring_q[0] <= head_d;
      for (int i = 1; i < stages; i++) begin
        ring_q[i] <= ring_q[i-1];
      end
      slot_q <= slot_d;
    end
  end

  assign tail = ring_q[stages-1];
  assign slot = slot_q;

endmodule

// File: rtl/jt51_sh_rw.sv
// jt51_sh_rw
// Access end of a time-multiplexed delay line: a circulating slot memory with
// one write port and one read port, each a req/ack handshake that waits for the
// addressed slot to pass the ring tail.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cen                clock enable for ring, slot counter and slot matching
//   wr_req/wr_slot/wr_data  write request (held until wr_ack), target, value
//   wr_ack             one-clk pulse: write done or rejected (slot out of range)
//   rd_req/rd_slot     read request (held until rd_valid), target
//   rd_data            last captured value
//   rd_valid           one-clk pulse: rd_data updated (or request rejected)
//   slot               index of the slot at the ring tail
//   dout               ring tail value
module jt51_sh_rw
  import jt51_sh_pkg::*;
#(
  parameter  int width  = 5,
  parameter  int stages = 32,
  localparam int SW     = slot_width(stages)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             wr_req,
  input  logic [SW-1:0]    wr_slot,
  input  logic [width-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  input  logic [SW-1:0]    rd_slot,
  output logic [width-1:0] rd_data,
  output logic             rd_valid,
  output logic [SW-1:0]    slot,
  output logic [width-1:0] dout
);

  // With a non-power-of-two depth some indices name no slot at all.
  function automatic logic slot_in_range(input logic [SW-1:0] s);
    return (int'(s) < stages);
  endfunction

  port_state_e      wr_state_q, wr_state_d;
  logic [SW-1:0]    wr_slot_q, wr_slot_d;
  logic [width-1:0] wr_data_q, wr_data_d;
  logic             wr_ack_q, wr_ack_d;
  logic             wr_hit;

  port_state_e      rd_state_q, rd_state_d;
  logic [SW-1:0]    rd_slot_q, rd_slot_d;
  logic [width-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic [SW-1:0]    ring_slot;
  logic [width-1:0] ring_tail;

  jt51_sh_ring #(
    .width  (width),
    .stages (stages)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .head_we  (wr_hit),
    .head_val (wr_data_q),
    .tail     (ring_tail),
    .slot     (ring_slot)
  );

  // Write port: latch request, wait for the slot to reach the tail, ack.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_slot_d  = wr_slot_q;
    wr_data_d  = wr_data_q;
    wr_hit     = 1'b0;
    case (wr_state_q)
      PORT_IDLE: begin
        if (wr_req && !wr_ack_q) begin
          wr_slot_d = wr_slot;
          wr_data_d = wr_data;
          // An index past the ring is acknowledged without touching it.
          if (slot_in_range(wr_slot)) begin
            wr_state_d = PORT_WAIT;
          end else begin
            wr_state_d = PORT_ACK;
          end
        end else begin
          wr_state_d = PORT_IDLE;
        end
      end
      PORT_WAIT: begin
        // The head takes the new value on the tick the old one leaves the tail.
        if (cen && (wr_slot_q == ring_slot)) begin
          wr_hit     = 1'b1;
          wr_state_d = PORT_ACK;
        end else begin
          wr_state_d = PORT_WAIT;
        end
      end
      PORT_ACK:  wr_state_d = PORT_IDLE;
      default:   wr_state_d = PORT_IDLE;
    endcase
    wr_ack_d = (wr_state_d == PORT_ACK);
  end

  // Read port: same handshake, capturing the tail instead of writing the head.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_slot_d  = rd_slot_q;
    rd_data_d  = rd_data_q;
    case (rd_state_q)
      PORT_IDLE: begin
        if (rd_req && !rd_valid_q) begin
          rd_slot_d = rd_slot;
          if (slot_in_range(rd_slot)) begin
            rd_state_d = PORT_WAIT;
          end else begin
            rd_state_d = PORT_ACK;
          end
        end else begin
          rd_state_d = PORT_IDLE;
        end
      end
      PORT_WAIT: begin
        // Tail is sampled before the edge, so a same-tick write is not seen.
        if (cen && (rd_slot_q == ring_slot)) begin
          rd_data_d  = ring_tail;
          rd_state_d = PORT_ACK;
        end else begin
          rd_state_d = PORT_WAIT;
        end
      end
      PORT_ACK:  rd_state_d = PORT_IDLE;
      default:   rd_state_d = PORT_IDLE;
    endcase
    rd_valid_d = (rd_state_d == PORT_ACK);
  end

  // Port FSM state, latched request fields and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= PORT_IDLE;
      wr_slot_q  <= '0;
      wr_data_q  <= '0;
      wr_ack_q   <= 1'b0;
      rd_state_q <= PORT_IDLE;
      rd_slot_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_slot_q  <= wr_slot_d;
      wr_data_q  <= wr_data_d;
      wr_ack_q   <= wr_ack_d;
      rd_state_q <= rd_state_d;
      rd_slot_q  <= rd_slot_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign wr_ack   = wr_ack_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign slot     = ring_slot;
  assign dout     = ring_tail;

endmodule

// File: tb/tb_jt51_sh_rw.sv
// tb_jt51_sh_rw
// Directed and randomized bench for jt51_sh_rw (width=5, stages=32). The
// reference keeps slot contents in a plain array indexed by slot number and
// models each port as a pending request that completes on the first cen tick
// (after the latch) at which the slot counter equals the target.
module tb_jt51_sh_rw;

  localparam int STAGES = 32;

  logic       clk = 1'b0;
  logic       rst, cen, wr_req, rd_req;
  logic [4:0] wr_slot, wr_data, rd_slot;
  logic       wr_ack, rd_valid;
  logic [4:0] rd_data, slot, dout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] m_mem [STAGES];
  int         m_slot;
  bit         m_wpend, m_rpend, e_wack, e_rvalid;
  int         m_wt, m_rt;
  logic [4:0] m_wd, e_rdata;

  jt51_sh_rw #(.width(5), .stages(STAGES)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .wr_req(wr_req), .wr_slot(wr_slot), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_slot(rd_slot), .rd_data(rd_data), .rd_valid(rd_valid),
    .slot(slot), .dout(dout)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the reference from the inputs seen at the edge, then compare.
  task automatic step();
    bit w_hit, r_hit;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < STAGES; i++) m_mem[i] = 5'd0;
      m_slot = 0; m_wpend = 1'b0; m_rpend = 1'b0;
      e_wack = 1'b0; e_rvalid = 1'b0; e_rdata = 5'd0;
    end else begin
      w_hit = m_wpend && cen && (m_wt == m_slot);
      r_hit = m_rpend && cen && (m_rt == m_slot);
      if (m_wpend) begin
        if (w_hit) m_wpend = 1'b0;
      end else if (wr_req && !e_wack) begin
        m_wpend = 1'b1; m_wt = int'(wr_slot); m_wd = wr_data;
      end
      if (m_rpend) begin
        if (r_hit) m_rpend = 1'b0;
      end else if (rd_req && !e_rvalid) begin
        m_rpend = 1'b1; m_rt = int'(rd_slot);
      end
      if (r_hit) e_rdata = m_mem[m_slot];
      e_wack   = w_hit;
      e_rvalid = r_hit;
      if (cen) begin
        if (w_hit) m_mem[m_slot] = m_wd;
        m_slot = (m_slot + 1) % STAGES;
      end
    end
    #1;
    chk("slot", slot, m_slot);
    chk("dout", dout, m_mem[m_slot]);
    chk("wr_ack", wr_ack, e_wack);
    chk("rd_valid", rd_valid, e_rvalid);
    chk("rd_data", rd_data, e_rdata);
  endtask

  task automatic go_to_slot(input int s);
    cen = 1'b1;
    for (int i = 0; i < 2 * STAGES && m_slot != s; i++) step();
  endtask

  // cen modes: 0 = always on, 1 = one clk in four, 2 = random
  function automatic logic cen_for(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (i % 4 == 3);
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic wait_wr(input int mode, input int max_clk, output int ticks);
    bit seen = 1'b0;
    ticks = 0;
    for (int i = 0; i < max_clk && !seen; i++) begin
      cen = cen_for(mode, i);
      if (cen) ticks++;
      step();
      if (wr_ack === 1'b1) begin seen = 1'b1; wr_req = 1'b0; end
    end
    if (!seen) chk("wr_ack_timeout", wr_ack, 1);
  endtask

  task automatic wait_rd(input int mode, input int max_clk, output int ticks);
    bit seen = 1'b0;
    ticks = 0;
    for (int i = 0; i < max_clk && !seen; i++) begin
      cen = cen_for(mode, i);
      if (cen) ticks++;
      step();
      if (rd_valid === 1'b1) begin seen = 1'b1; rd_req = 1'b0; end
    end
    if (!seen) chk("rd_valid_timeout", rd_valid, 1);
  endtask

  initial begin
    int t, wr_at, rd_at;
    logic [4:0] d;
    rst = 1'b1; cen = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_slot = 5'd0; wr_data = 5'd0; rd_slot = 5'd0;
    step();
    cen = 1'b1;
    step();
    rst = 1'b0;

    // 1: empty ring circulates zeros, slot counts and wraps
    cen = 1'b1;
    for (int i = 0; i < STAGES; i++) step();
    chk("wrap_slot", slot, 0);

    // 2: write slot 10 latched at slot 3 takes 7 ticks; read it back
    go_to_slot(3);
    wr_req = 1'b1; wr_slot = 5'd10; wr_data = 5'h15; step();
    wait_wr(0, 80, t);
    chk("wr_lat_7", t, 7);
    rd_req = 1'b1; rd_slot = 5'd10; step();
    wait_rd(0, 80, t);
    chk("rd_slot10", rd_data, 5'h15);
    for (int i = 0; i < STAGES; i++) step();

    // 3: latch on the matching tick misses and waits a full revolution
    go_to_slot(3);
    wr_req = 1'b1; wr_slot = 5'd3; wr_data = 5'h0A; step();
    wait_wr(0, 80, t);
    chk("wr_lat_full", t, 32);

    // 4: simultaneous read and write of slot 7 returns the old value
    wr_req = 1'b1; wr_slot = 5'd7; wr_data = 5'h02; step();
    wait_wr(0, 80, t);
    wr_req = 1'b1; wr_slot = 5'd7; wr_data = 5'h1F;
    rd_req = 1'b1; rd_slot = 5'd7; step();
    wr_at = -1; rd_at = -2;
    for (int i = 0; i < 80 && (wr_req || rd_req); i++) begin
      step();
      if (wr_ack === 1'b1) begin wr_at = i; wr_req = 1'b0; end
      if (rd_valid === 1'b1) begin rd_at = i; rd_req = 1'b0; end
    end
    chk("same_clk", wr_at, rd_at);
    chk("rd_old", rd_data, 5'h02);
    rd_req = 1'b1; rd_slot = 5'd7; step();
    wait_rd(0, 80, t);
    chk("rd_new", rd_data, 5'h1F);

    // 5: sparse cen; hit only on a cen tick, single-clk ack
    d = 5'($urandom);
    wr_req = 1'b1; wr_slot = 5'($urandom); wr_data = d; cen = 1'b0; step();
    wait_wr(1, 200, t);
    chk("hit_on_cen", cen, 1);
    chk("wr_lat_range", (t >= 1 && t <= 32), 1);
    cen = 1'b0; step();
    chk("wr_ack_width", wr_ack, 0);

    // 6: reset while both ports wait drops them and clears the ring
    wr_req = 1'b1; wr_slot = 5'd20; wr_data = 5'h11;
    rd_req = 1'b1; rd_slot = 5'd21; cen = 1'b0; step();
    wr_req = 1'b0; rd_req = 1'b0;
    step(); step();
    rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cen = 1'b1; step();
      chk("no_ack_after_rst", {wr_ack, rd_valid}, 2'b00);
    end
    for (int i = 0; i < STAGES; i++) begin
      step();
      chk("zero_after_rst", dout, 0);
    end
    wr_req = 1'b1; wr_slot = 5'd9; wr_data = 5'h0C; step();
    wait_wr(2, 300, t);
    rd_req = 1'b1; rd_slot = 5'd9; step();
    wait_rd(2, 300, t);
    chk("rd_after_rst", rd_data, 5'h0C);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cen = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      if (!wr_req && !wr_ack && $urandom_range(0, 5) == 0) begin
        wr_req = 1'b1; wr_slot = 5'($urandom); wr_data = 5'($urandom);
      end
      if (!rd_req && !rd_valid && $urandom_range(0, 5) == 0) begin
        rd_req = 1'b1; rd_slot = 5'($urandom);
      end
      step();
      if (wr_ack === 1'b1) wr_req = 1'b0;
      if (rd_valid === 1'b1) rd_req = 1'b0;
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
